// File: rtl/tone_sequencer.sv
// tone_sequencer: multi-song square-wave tone player stepping through an external note table.
// Define TONE_SEQ_GAP_EN to insert a silent articulation gap of GAP_TICKS cycles between notes.
module tone_sequencer #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int NUM_SONGS = 4,
  parameter int MAX_NOTES = 32,
  parameter int PERIOD_W = 20,
  parameter int DUR_W = 5,
  parameter int GAP_TICKS = CLK_FREQ / 50,
  localparam int SONG_W = NUM_SONGS > 1 ? $clog2(NUM_SONGS) : 1,
  localparam int IDX_W = MAX_NOTES > 1 ? $clog2(MAX_NOTES) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [SONG_W-1:0]   song_sel,
  output logic [SONG_W-1:0]   rom_song,
  output logic [IDX_W-1:0]    rom_idx,
  input  logic [PERIOD_W-1:0] rom_period,
  input  logic [DUR_W-1:0]    rom_dur,
  input  logic                rom_last,
  output logic                audio_out,
  output logic                aud_sd,
  output logic                busy,
  output logic                done
);
  localparam int TICK_DIV = CLK_FREQ / 8;
  localparam int DW = DUR_W + $clog2(TICK_DIV) + 1;
`ifdef TONE_SEQ_GAP_EN
  localparam int GW = $clog2(GAP_TICKS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
`endif
  state_t state;
  logic [PERIOD_W-1:0] period_q, tone_cnt;
  logic [DW-1:0] dur_cnt, dur_ld;
  logic last_q, last_end;
  assign dur_ld = DW'(rom_dur == '0 ? DUR_W'(1) : rom_dur) * DW'(TICK_DIV);
  assign last_end = last_q | (rom_idx == IDX_W'(MAX_NOTES - 1));
  assign busy = state != IDLE;
  assign aud_sd = busy;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rom_song <= '0;
      rom_idx <= '0;
      period_q <= '0;
      tone_cnt <= '0;
      dur_cnt <= '0;
      last_q <= 1'b0;
      audio_out <= 1'b0;
      done <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        audio_out <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            rom_song <= song_sel;
            rom_idx <= '0;
            state <= LOAD;
          end
          LOAD: begin
            period_q <= rom_period;
            last_q <= rom_last;
            dur_cnt <= dur_ld;
            tone_cnt <= '0;
            audio_out <= 1'b0;
            state <= PLAY;
          end
          PLAY: if (dur_cnt == DW'(1)) begin
            audio_out <= 1'b0;
            if (last_end && !loop_en) begin
              done <= 1'b1;
              state <= IDLE;
            end else begin
              rom_idx <= last_end ? '0 : rom_idx + IDX_W'(1);
`ifdef TONE_SEQ_GAP_EN
              gap_cnt <= GW'(GAP_TICKS);
              state <= GAP;
`else
              state <= LOAD;
`endif
            end
          end else begin
            dur_cnt <= dur_cnt - DW'(1);
            // period 0 is a rest: counter frozen, output stays low
            if (period_q != '0) begin
              tone_cnt <= tone_cnt == period_q ? '0 : tone_cnt + PERIOD_W'(1);
              audio_out <= tone_cnt == period_q ? ~audio_out : audio_out;
            end
          end
`ifdef TONE_SEQ_GAP_EN
          GAP: begin
            gap_cnt <= gap_cnt - GW'(1);
            state <= gap_cnt == GW'(1) ? LOAD : GAP;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed checks of tone_sequencer against a small behavioural note table.
module tb_tone_sequencer;
`ifdef TONE_SEQ_GAP_EN
  localparam int GAPC = 3;
`else
  localparam int GAPC = 0;
`endif
  logic clock = 0, reset = 1, start = 0, stop = 0, loop_en = 0;
  logic [1:0] song_sel = 0, rom_song;
  logic [2:0] rom_idx;
  logic [19:0] rom_period;
  logic [4:0] rom_dur;
  logic rom_last, audio_out, aud_sd, busy, done;
  int checks = 0, errors = 0;

  tone_sequencer #(.CLK_FREQ(80), .NUM_SONGS(4), .MAX_NOTES(8), .GAP_TICKS(3)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .song_sel(song_sel), .rom_song(rom_song), .rom_idx(rom_idx), .rom_period(rom_period),
    .rom_dur(rom_dur), .rom_last(rom_last), .audio_out(audio_out), .aud_sd(aud_sd),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // song 1: {p=3,d=2},{rest,d=1,last}; song 2: 8 entries p=1,d=1 except entry 3 = rest with d=0
  always_comb begin
    rom_period = 20'd2;
    rom_dur = 5'd1;
    rom_last = 1'b1;
    if (rom_song == 2'd1) begin
      rom_period = rom_idx == 3'd0 ? 20'd3 : 20'd0;
      rom_dur = rom_idx == 3'd0 ? 5'd2 : 5'd1;
      rom_last = rom_idx != 3'd0;
    end else if (rom_song == 2'd2) begin
      rom_period = rom_idx == 3'd3 ? 20'd0 : 20'd1;
      rom_dur = rom_idx == 3'd3 ? 5'd0 : 5'd1;
      rom_last = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [1:0] s, input logic lp);
    song_sel = s;
    loop_en = lp;
    start = 1;
    tick(1);
    start = 0;
  endtask

  initial begin
    #2;
    check("rst_audio", audio_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sd", aud_sd, 0);
    check("rst_done", done, 0);
    check("rst_idx", rom_idx, 0);
    check("rst_song", rom_song, 0);
    tick(1);
    reset = 0;
    tick(1);
    // one-shot song 1
    go(2'd1, 0);
    check("t1_busy", busy, 1);
    check("t1_song", rom_song, 1);
    check("t1_idx0", rom_idx, 0);
    tick(1);
    for (int k = 0; k < 20; k++) begin
      check("t1_note0", audio_out, (k / 4) % 2);
      tick(1);
    end
    for (int k = 0; k < GAPC; k++) begin
      check("t1_gap_audio", audio_out, 0);
      check("t1_gap_idx", rom_idx, 1);
      tick(1);
    end
    check("t1_load_idx", rom_idx, 1);
    check("t1_load_audio", audio_out, 0);
    tick(1);
    for (int k = 0; k < 10; k++) begin
      check("t1_rest_audio", audio_out, 0);
      check("t1_rest_done", done, 0);
      check("t1_rest_busy", busy, 1);
      tick(1);
    end
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_sd_end", aud_sd, 0);
    tick(1);
    check("t1_done_pulse", done, 0);
    // looping song 1, then stop mid-note
    go(2'd1, 1);
    tick(1 + 20 + GAPC);
    check("t2_idx1", rom_idx, 1);
    check("t2_done_a", done, 0);
    tick(11);
    check("t2_wrap_idx", rom_idx, 0);
    check("t2_wrap_done", done, 0);
    check("t2_wrap_busy", busy, 1);
    tick(GAPC + 1 + 5);
    check("t2_audio_mid", audio_out, 1);
    stop = 1;
    tick(1);
    stop = 0;
    check("t2_stop_busy", busy, 0);
    check("t2_stop_audio", audio_out, 0);
    check("t2_stop_sd", aud_sd, 0);
    check("t2_stop_done", done, 0);
    tick(1);
    check("t2_stop_done2", done, 0);
    // song 2: no last flag, wraps at MAX_NOTES-1, zero-duration entry
    go(2'd2, 1);
    for (int i = 0; i < 8; i++) begin
      check("t3_idx", rom_idx, i);
      if (i == 3) begin
        tick(6);
        check("t3_rest_audio", audio_out, 0);
        tick(4);
        check("t3_dur0_idx", rom_idx, 3);
        check("t3_dur0_busy", busy, 1);
        tick(1 + GAPC);
      end else if (i == 1) begin
        tick(3);
        check("t3_p1_audio", audio_out, 1);
        tick(8 + GAPC);
      end else begin
        tick(11 + GAPC);
      end
    end
    check("t3_wrap_idx", rom_idx, 0);
    check("t3_wrap_done", done, 0);
    go(2'd3, 1);
    check("t3_song_hold", rom_song, 2);
    check("t3_still_busy", busy, 1);
    stop = 1;
    tick(1);
    stop = 0;
    check("t3_stop_busy", busy, 0);
    // start and stop together
    song_sel = 2'd1;
    start = 1;
    stop = 1;
    tick(1);
    start = 0;
    stop = 0;
    check("t4_idle", busy, 0);
    tick(1);
    check("t4_idle2", busy, 0);
    // async reset mid-play
    go(2'd2, 0);
    tick(11 + GAPC + 1 + 3);
    check("t5_pre_audio", audio_out, 1);
    check("t5_pre_idx", rom_idx, 1);
    #2 reset = 1;
    #1;
    check("t5_audio", audio_out, 0);
    check("t5_busy", busy, 0);
    check("t5_sd", aud_sd, 0);
    check("t5_idx", rom_idx, 0);
    check("t5_song", rom_song, 0);
    check("t5_done", done, 0);
    tick(1);
    reset = 0;
    tick(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
